filter_mode_ctrl: RTL

Frame-synchronous controller for the camera-to-VGA pixel effect chain. It turns a pushbutton press into a cyclic effect selection: passthrough, blur, edge, cartoon. It then applies the new selection only at a vertical-sync boundary, so a frame is never split between two effects. Its registered one-hot enables drive the blur, edge and cartoon stages' `en` inputs.

---
 rtl/filter_mode_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/filter_mode_ctrl.sv
// -----------------------------------------------------------------------------
// filter_mode_ctrl
//
// Frame-synchronous effect selector for the camera-to-VGA pixel chain.
// A debounced pushbutton press advances a requested effect
// (pass -> blur -> edge -> cartoon -> pass). The request is committed to the
// active mode only at a vertical-sync falling edge, so a frame is never split
// between two effects.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable synced-key cycles needed to accept a level (>= 2)
//   AUTO_FRAMES     : frames between automatic advances (auto-cycle build only)
//
// Ports:
//   clk        in   pixel/system clock
//   rst_n      in   asynchronous active-low reset
//   key_n      in   raw pushbutton, active-low, asynchronous, bouncy
//   vs_n       in   vertical sync, active-low, asynchronous-safe
//   auto_sw    in   1 = auto-cycle request (used only with FILTER_AUTO_CYCLE_EN)
//   mode       out  active effect: 0 pass, 1 blur, 2 edge, 3 cartoon
//   blur_en    out  registered, high when mode == 1
//   edge_en    out  registered, high when mode == 2
//   cartoon_en out  registered, high when mode == 3
//   pending    out  a requested mode is waiting for the next frame boundary
//
// Build option:
//   FILTER_AUTO_CYCLE_EN : when defined, adds a frame counter that injects a
//                          press every AUTO_FRAMES frames while auto_sw = 1.
// -----------------------------------------------------------------------------
module filter_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_FRAMES     = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       vs_n,
    input  logic       auto_sw,
    output logic [1:0] mode,
    output logic       blur_en,
    output logic       edge_en,
    output logic       cartoon_en,
    output logic       pending
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronisers (idle level is 1 for both active-low inputs)
    // -------------------------------------------------------------------------
    logic key_s1, key_s2;
    logic vs_s1, vs_s2, vs_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            vs_s1  <= 1'b1;
            vs_s2  <= 1'b1;
            vs_s3  <= 1'b1;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            vs_s1  <= vs_n;
            vs_s2  <= vs_s1;
            vs_s3  <= vs_s2;
        end
    end

    // Frame boundary: synced vs_n just went low.
    logic fb;
    assign fb = vs_s3 & ~vs_s2;

    // -------------------------------------------------------------------------
    // Debounce. press_key is registered on the same edge key_stable falls, so
    // it is a one-cycle pulse that already sits in a flop.
    // -------------------------------------------------------------------------
    logic            key_stable;
    logic [DB_W-1:0] db_cnt;
    logic            press_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_stable <= 1'b1;
            db_cnt     <= '0;
            press_key  <= 1'b0;
        end else begin
            press_key <= 1'b0;
            if (key_s2 != key_stable) begin
                if (db_cnt == DB_LAST) begin
                    key_stable <= key_s2;
                    db_cnt     <= '0;
                    press_key  <= ~key_s2;   // only the 1->0 transition counts
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Press source: manual only, or manual plus frame-counted auto advance.
    // -------------------------------------------------------------------------
    logic press_any;

`ifdef FILTER_AUTO_CYCLE_EN
    localparam int AF_W = ($clog2(AUTO_FRAMES) > 8) ? $clog2(AUTO_FRAMES) : 8;
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTO_FRAMES - 1);

    logic [AF_W-1:0] auto_cnt;
    logic            auto_press;

    // auto_sw is a slow slide switch; a late sample only shifts the first
    // counted frame, so it is used without a synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt   <= '0;
            auto_press <= 1'b0;
        end else begin
            auto_press <= 1'b0;
            if (!auto_sw || press_key) begin
                auto_cnt <= '0;
            end else if (fb) begin
                if (auto_cnt == AF_LAST) begin
                    auto_cnt   <= '0;
                    auto_press <= 1'b1;   // lands one cycle after this fb
                end else begin
                    auto_cnt <= auto_cnt + 1'b1;
                end
            end
        end
    end

    assign press_any = press_key | auto_press;
`else
    // Feature compiled out: the switch and frame count have no effect.
    logic unused_auto_sw;
    assign unused_auto_sw = auto_sw;
    localparam int UNUSED_AUTO_FRAMES = AUTO_FRAMES;

    assign press_any = press_key;
`endif

    // -------------------------------------------------------------------------
    // Mode FSM. req_mode accumulates presses independent of mode; mode copies
    // the pre-increment req_mode at a frame boundary while PENDING.
    // -------------------------------------------------------------------------
    state_t     state, state_nxt;
    logic [1:0] req_mode, req_nxt;
    logic [1:0] mode_nxt;

    always_comb begin
        state_nxt = state;
        req_nxt   = req_mode;
        mode_nxt  = mode;

        if (press_any) begin
            req_nxt = req_mode + 2'd1;
        end

        case (state)
            IDLE: begin
                if (press_any) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (fb) begin
                    mode_nxt = req_mode;
                    // A press on the boundary cycle keeps a new request open.
                    if (!press_any) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Enables decode mode_nxt so they switch on the same edge as mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_mode   <= 2'd0;
            mode       <= 2'd0;
            blur_en    <= 1'b0;
            edge_en    <= 1'b0;
            cartoon_en <= 1'b0;
            pending    <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_mode   <= req_nxt;
            mode       <= mode_nxt;
            blur_en    <= (mode_nxt == 2'd1);
            edge_en    <= (mode_nxt == 2'd2);
            cartoon_en <= (mode_nxt == 2'd3);
            pending    <= (state_nxt == PENDING);
        end
    end

endmodule
